// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Front-end fetch stage. It reads byte-wide instruction memory through a
// req/ready handshake, walks the program counter, and assembles 1-3 byte
// instructions (opcode, data1, data2). Each complete bundle is then offered to
// the core until the core acknowledges it. The core can redirect fetch at any
// time with a single-cycle jump pulse.
//
// Instruction length comes from opcode[7:6]:
//   00 -> 1 byte, 01 -> 2 bytes, 10/11 -> 3 bytes.
//
// Ports:
//   i_clk, i_rst     clock and synchronous active-high reset
//   i_hold           stall; no memory request is issued while it is high
//   i_jump           redirect pulse; the target is i_jump_addr
//   o_mem_req        memory read request (combinational from state and hold)
//   o_mem_addr       byte address of the request (the current pc)
//   i_mem_ready      read data valid this cycle
//   i_mem_data       read data byte
//   o_instr_ready    instruction bundle valid
//   i_instr_ack      consumer takes the bundle this cycle
//   o_opcode         opcode byte
//   o_data1          first operand byte, 0 if unused
//   o_data2          second operand byte, 0 if unused
//   o_instr_pc       address of the opcode byte
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_hold,
  input  logic              i_jump,
  input  logic [ADDR_W-1:0] i_jump_addr,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ready,
  input  logic [7:0]        i_mem_data,
  output logic              o_instr_ready,
  input  logic              i_instr_ack,
  output logic [7:0]        o_opcode,
  output logic [7:0]        o_data1,
  output logic [7:0]        o_data2,
  output logic [ADDR_W-1:0] o_instr_pc
);

  typedef enum logic [1:0] {
    FETCH_OP = 2'd0,
    FETCH_D1 = 2'd1,
    FETCH_D2 = 2'd2,
    PRESENT  = 2'd3
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] instr_pc_reg;
  logic [7:0]        opcode_reg;
  logic [7:0]        data1_reg;
  logic [7:0]        data2_reg;
  logic              instr_ready_reg;

  logic              fetching;
  logic              take_byte;
  logic [ADDR_W-1:0] pc_next;

  // A request is only meaningful in a fetch state and while not stalled.
  // It is also suppressed while reset is held so memory sees no traffic.
  assign fetching   = (state_reg != PRESENT);
  assign o_mem_req  = fetching && !i_hold && !i_rst;
  assign o_mem_addr = pc_reg;
  assign take_byte  = o_mem_req && i_mem_ready;

  // Natural wrap at 2^ADDR_W lets an instruction straddle the top of memory.
  assign pc_next = pc_reg + ADDR_W'(1);

  assign o_instr_ready = instr_ready_reg;
  assign o_opcode      = opcode_reg;
  assign o_data1       = data1_reg;
  assign o_data2       = data2_reg;
  assign o_instr_pc    = instr_pc_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg       <= FETCH_OP;
      pc_reg          <= RESET_PC;
      instr_pc_reg    <= RESET_PC;
      opcode_reg      <= 8'h00;
      data1_reg       <= 8'h00;
      data2_reg       <= 8'h00;
      instr_ready_reg <= 1'b0;
    end else if (i_jump) begin
      // Redirect beats ack and memory data: any partial or presented
      // bundle is dropped and the byte returned this cycle is ignored.
      state_reg       <= FETCH_OP;
      pc_reg          <= i_jump_addr;
      instr_ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        FETCH_OP: begin
          if (take_byte) begin
            opcode_reg   <= i_mem_data;
            data1_reg    <= 8'h00;
            data2_reg    <= 8'h00;
            instr_pc_reg <= pc_reg;
            pc_reg       <= pc_next;
            if (i_mem_data[7:6] == 2'b00) begin
              state_reg       <= PRESENT;
              instr_ready_reg <= 1'b1;
            end else begin
              state_reg <= FETCH_D1;
            end
          end
        end

        FETCH_D1: begin
          if (take_byte) begin
            data1_reg <= i_mem_data;
            pc_reg    <= pc_next;
            if (opcode_reg[7:6] == 2'b01) begin
              state_reg       <= PRESENT;
              instr_ready_reg <= 1'b1;
            end else begin
              state_reg <= FETCH_D2;
            end
          end
        end

        FETCH_D2: begin
          if (take_byte) begin
            data2_reg       <= i_mem_data;
            pc_reg          <= pc_next;
            state_reg       <= PRESENT;
            instr_ready_reg <= 1'b1;
          end
        end

        PRESENT: begin
          // Hold does not block the ack; the next request goes out on the
          // cycle after the ack, from FETCH_OP.
          if (i_instr_ack) begin
            state_reg       <= FETCH_OP;
            instr_ready_reg <= 1'b0;
          end
        end

        default: begin
          state_reg       <= FETCH_OP;
          instr_ready_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Drives instr_fetch against a byte-array memory with programmable wait
// states. A transaction-level reference model (bytes collected so far, bundle
// contents, presenting flag, pc) predicts every output each cycle. Directed
// scenarios are followed by a long randomized run.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int          ADDR_W   = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic              i_hold = 1'b0;
  logic              i_jump = 1'b0;
  logic [ADDR_W-1:0] i_jump_addr = '0;
  logic              o_mem_req;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              i_mem_ready = 1'b0;
  logic [7:0]        i_mem_data = 8'h00;
  logic              o_instr_ready;
  logic              i_instr_ack = 1'b0;
  logic [7:0]        o_opcode;
  logic [7:0]        o_data1;
  logic [7:0]        o_data2;
  logic [ADDR_W-1:0] o_instr_pc;

  instr_fetch #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_hold        (i_hold),
    .i_jump        (i_jump),
    .i_jump_addr   (i_jump_addr),
    .o_mem_req     (o_mem_req),
    .o_mem_addr    (o_mem_addr),
    .i_mem_ready   (i_mem_ready),
    .i_mem_data    (i_mem_data),
    .o_instr_ready (o_instr_ready),
    .i_instr_ack   (i_instr_ack),
    .o_opcode      (o_opcode),
    .o_data1       (o_data1),
    .o_data2       (o_data2),
    .o_instr_pc    (o_instr_pc)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  // Memory model
  logic [7:0] mem [65536];
  int         wait_cfg    = 0;   // -1 selects random 0..2 per access
  int         wait_left   = 0;
  logic       force_ready = 1'b0;

  // Reference model state
  logic        m_valid = 1'b0;
  logic [15:0] m_pc    = '0;
  int          m_cnt   = 0;
  int          m_need  = 0;
  logic        m_pres  = 1'b0;
  logic [7:0]  m_op    = '0;
  logic [7:0]  m_d1    = '0;
  logic [7:0]  m_d2    = '0;
  logic [15:0] m_ipc   = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ilen(input logic [7:0] op);
    if (op[7:6] == 2'b00) return 1;
    if (op[7:6] == 2'b01) return 2;
    return 3;
  endfunction

  function automatic int next_wait();
    if (wait_cfg < 0) return int'($urandom_range(0, 2));
    return wait_cfg;
  endfunction

  // One clock: apply inputs at the falling edge, compare outputs with the
  // model, advance the model with the inputs the rising edge will see.
  task automatic cycle(input logic rst, input logic hold, input logic jump,
                       input logic [15:0] jaddr, input logic ack);
    logic exp_req;
    @(negedge i_clk);
    i_rst       = rst;
    i_hold      = hold;
    i_jump      = jump;
    i_jump_addr = jaddr;
    i_instr_ack = ack;
    #1;
    i_mem_ready = force_ready || ((o_mem_req === 1'b1) && (wait_left == 0));
    i_mem_data  = i_mem_ready ? mem[o_mem_addr] : 8'($urandom);
    #1;

    if (m_valid) begin
      exp_req = !rst && !m_pres && !hold;
      check("mem_req", 32'(o_mem_req), 32'(exp_req));
      if (exp_req) check("mem_addr", 32'(o_mem_addr), 32'(m_pc));
      check("instr_ready", 32'(o_instr_ready), 32'(m_pres));
      check("opcode", 32'(o_opcode), 32'(m_op));
      check("data1", 32'(o_data1), 32'(m_d1));
      check("data2", 32'(o_data2), 32'(m_d2));
      check("instr_pc", 32'(o_instr_pc), 32'(m_ipc));
    end

    if (rst) begin
      m_valid = 1'b1;
      m_pc = RESET_PC; m_cnt = 0; m_pres = 1'b0;
      m_op = '0; m_d1 = '0; m_d2 = '0; m_ipc = RESET_PC;
    end else if (jump) begin
      m_pc = jaddr; m_cnt = 0; m_pres = 1'b0;
    end else if (m_pres) begin
      if (ack) begin
        $display("txn pc=%04h op=%02h d1=%02h d2=%02h", m_ipc, m_op, m_d1, m_d2);
        m_pres = 1'b0;
        m_cnt  = 0;
      end
    end else if (!hold && i_mem_ready) begin
      if (m_cnt == 0) begin
        m_op = i_mem_data; m_d1 = '0; m_d2 = '0; m_ipc = m_pc;
        m_need = ilen(i_mem_data);
      end else if (m_cnt == 1) begin
        m_d1 = i_mem_data;
      end else begin
        m_d2 = i_mem_data;
      end
      m_cnt++;
      m_pc = m_pc + 16'd1;
      if (m_cnt == m_need) m_pres = 1'b1;
    end

    if (rst || jump) wait_left = next_wait();
    else if (o_mem_req === 1'b1) begin
      if (i_mem_ready) wait_left = next_wait();
      else if (wait_left > 0) wait_left--;
    end

    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic run_until_ready(input int max_cycles);
    int n;
    n = 0;
    while (o_instr_ready !== 1'b1 && n < max_cycles) begin
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      n++;
    end
    if (o_instr_ready !== 1'b1) check("ready_timeout", 32'(o_instr_ready), 32'd1);
  endtask

  task automatic ack();
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);

    // 1: reset, 1-byte opcode at 0x0000, zero wait
    mem[16'h0000] = 8'h05;
    wait_cfg = 0;
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    check("rst_mem_req", 32'(o_mem_req), 32'd0);
    check("rst_ready", 32'(o_instr_ready), 32'd0);
    check("rst_instr_pc", 32'(o_instr_pc), 32'(RESET_PC));
    run_until_ready(10);
    check("t1_opcode", 32'(o_opcode), 32'h05);
    check("t1_data1", 32'(o_data1), 32'h00);
    check("t1_instr_pc", 32'(o_instr_pc), 32'h0000);
    ack();
    idle(1);

    // 2: 3-byte instruction at 0x0010 via jump, 2 wait cycles per byte
    mem[16'h0010] = 8'h80; mem[16'h0011] = 8'h12; mem[16'h0012] = 8'h34;
    wait_cfg = 2;
    cycle(1'b0, 1'b0, 1'b1, 16'h0010, 1'b0);
    run_until_ready(30);
    check("t2_opcode", 32'(o_opcode), 32'h80);
    check("t2_data1", 32'(o_data1), 32'h12);
    check("t2_data2", 32'(o_data2), 32'h34);
    check("t2_instr_pc", 32'(o_instr_pc), 32'h0010);
    ack();

    // 3: 2-byte 0x41/0xAA, ack withheld 5 cycles
    mem[16'h0013] = 8'h41; mem[16'h0014] = 8'hAA;
    mem[16'h0015] = 8'hC0; mem[16'h0016] = 8'h11; mem[16'h0017] = 8'h22;
    wait_cfg = 0;
    run_until_ready(20);
    idle(5);
    check("t3_opcode", 32'(o_opcode), 32'h41);
    check("t3_data2", 32'(o_data2), 32'h00);
    ack();

    // 4: hold in FETCH_D1 while memory claims ready
    idle(1);
    force_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    force_ready = 1'b0;
    run_until_ready(20);
    check("t4_data1", 32'(o_data1), 32'h11);
    check("t4_instr_pc", 32'(o_instr_pc), 32'h0015);

    // 5: jump together with ack, then jump during a waited D2 fetch
    cycle(1'b0, 1'b0, 1'b1, 16'h2000, 1'b1);
    check("t5_ready_drop", 32'(o_instr_ready), 32'd0);
    mem[16'h2000] = 8'h90;
    wait_cfg = 3;
    idle(10);
    cycle(1'b0, 1'b0, 1'b1, 16'h3000, 1'b0);
    run_until_ready(40);
    ack();

    // 6: wrap at 0xFFFF, then reset mid FETCH_D2
    mem[16'hFFFF] = 8'h40; mem[16'h0000] = 8'h77; mem[16'h0001] = 8'hC5;
    wait_cfg = 0;
    cycle(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
    run_until_ready(10);
    check("t6_instr_pc", 32'(o_instr_pc), 32'hFFFF);
    check("t6_data1", 32'(o_data1), 32'h77);
    ack();
    wait_cfg = 2;
    idle(7);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    check("t6_rst_opcode", 32'(o_opcode), 32'h00);
    check("t6_rst_data1", 32'(o_data1), 32'h00);
    check("t6_rst_ready", 32'(o_instr_ready), 32'd0);
    check("t6_rst_instr_pc", 32'(o_instr_pc), 32'(RESET_PC));

    // Randomized run
    wait_cfg = -1;
    for (int i = 0; i < 4000; i++) begin
      logic r_rst, r_hold, r_jump, r_ack;
      logic [15:0] r_addr;
      r_rst  = ($urandom_range(0, 399) == 0);
      r_hold = ($urandom_range(0, 4) == 0);
      r_jump = ($urandom_range(0, 29) == 0);
      r_ack  = ($urandom_range(0, 1) == 0);
      r_addr = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFE + $urandom_range(0, 1))
                                           : 16'($urandom);
      cycle(r_rst, r_hold, r_jump, r_addr, r_ack);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit in case a wait loop misbehaves.
  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Front-end stage that feeds the cpu core. Reads byte-wide instruction memory through a req/ready handshake and tracks the program counter. Assembles variable-length instructions of 1–3 bytes (opcode, data1, data2) and presents each one, with its address, to the cpu's i_opcode/i_data1/i_data2/i_instr_ready inputs. Accepts redirects (jump/branch/return) from the cpu.

Parameters:
ADDR_W, 16, width of PC and memory address
RESET_PC, 16'h0000, PC value loaded on reset

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  synchronous reset, active-high
i_hold  in  1  stall: no new memory requests issued while high
i_jump  in  1  redirect request, single-cycle pulse
i_jump_addr  in  ADDR_W  redirect target
o_mem_req  out  1  memory read request
o_mem_addr  out  ADDR_W  byte address of request
i_mem_ready  in  1  read data valid this cycle (meaningful only while o_mem_req=1)
i_mem_data  in  8  read data
o_instr_ready  out  1  instruction bundle valid
i_instr_ack  in  1  consumer takes bundle this cycle
o_opcode  out  8  instruction opcode
o_data1  out  8  first operand byte, 0 if unused
o_data2  out  8  second operand byte, 0 if unused
o_instr_pc  out  ADDR_W  address of the opcode byte

Behaviour:
- Reset (i_rst sampled high at an edge):
  - pc=RESET_PC, state=FETCH_OP.
  - o_mem_req=0, o_instr_ready=0.
  - o_opcode=o_data1=o_data2=0, o_instr_pc=RESET_PC.
  - Reset overrides all other inputs, including mid-instruction.
- States: FETCH_OP, FETCH_D1, FETCH_D2, PRESENT.
- Length decode from the fetched opcode: opcode[7:6]=00 gives 1 byte; 01 gives 2; 10 or 11 gives 3.
- Fetch states, i_hold=0:
  - o_mem_req=1 (combinational from state and hold); o_mem_addr=pc.
  - On the cycle i_mem_ready=1, latch i_mem_data into the current byte slot and set pc<=pc+1.
  - FETCH_OP: latch opcode, record o_instr_pc=pc, clear data1/data2 to 0. Then go to PRESENT if length 1, else FETCH_D1.
  - FETCH_D1: go to PRESENT if length 2, else FETCH_D2.
  - FETCH_D2: go to PRESENT.
  - If i_mem_ready=0, hold state and address; the request stays asserted.
- i_hold=1 in a fetch state:
  - o_mem_req=0; state, pc and partial bundle frozen; i_mem_ready ignored.
  - Memory must tolerate req dropping without ready; the read is reissued when hold falls.
- PRESENT:
  - o_instr_ready=1; o_opcode, o_data1, o_data2 and o_instr_pc stable; o_mem_req=0.
  - Leave only when i_instr_ack=1, then go to FETCH_OP. The next request is issued on the following cycle.
  - i_hold does not block the ack.
  - i_instr_ack outside PRESENT is ignored.
- Latency: a length-N instruction with zero-wait memory takes N cycles of fetch. o_instr_ready rises on cycle N+1 after entering FETCH_OP.
- Redirect (i_jump=1 at an edge, any state, any hold or ack value):
  - pc<=i_jump_addr, state<=FETCH_OP, o_instr_ready<=0.
  - A bundle being presented is discarded even if acked in the same cycle (jump wins).
  - A pending memory read is abandoned; data returned in that cycle is dropped.
  - Priority: reset > jump > ack/mem_ready.
- PC arithmetic: modulo 2^ADDR_W. pc=16'hFFFF increments to 16'h0000; an instruction may straddle the wrap.
- Output registers are updated only on the events above; no X on any output after reset.

Test Plan:
- Reset, memory holding 0x05 at 0x0000 with zero wait -> o_mem_addr=0x0000 and req one cycle; o_instr_ready rises next cycle with opcode 0x05, data1=data2=0, instr_pc 0x0000. After ack, next req is at 0x0001.
- Memory bytes 0x80,0x12,0x34 at 0x0010, PC=0x0010 via jump, ready asserted after 2 wait cycles per byte -> bundle 0x80/0x12/0x34, instr_pc 0x0010; next fetch at 0x0013.
- Opcode 0x41,0xAA followed by a 3-byte instruction; ack withheld 5 cycles -> bundle 0x41/0xAA/0x00 held stable for 5 cycles with no mem req. After ack, fetch resumes at pc+2.
- i_hold high while in FETCH_D1 with ready asserted -> o_mem_req=0, ready ignored, no pc change. After hold drops, D1 is re-requested at the same address.
- i_jump to 0x2000 in the same cycle as i_instr_ack in PRESENT -> bundle not re-presented; o_instr_ready=0 next cycle and next req addr=0x2000. Also: jump during a waited D2 fetch -> partial instruction discarded.
- PC=0xFFFF, 2-byte opcode 0x40 -> data1 fetched from 0x0000, instr_pc 0xFFFF, next fetch 0x0001. Reset asserted mid-FETCH_D2 -> all outputs at reset values next cycle.
